// File: rtl/inst_fetch_translate.sv
// Fetch-address stage: owns the fetch PC, turns the MMU result into an I-cache
// request or a fetch exception, and holds one fetch record for decode.
// inst_mmu_result layout: [35:4] paddr, [3] miss, [2] invalid, [1] illegal, [0] uncached.
module inst_fetch_translate #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        stall,
  output logic [31:0] inst_vaddr,
  input  logic [35:0] inst_mmu_result,
  output logic        icache_req,
  output logic [31:0] icache_paddr,
  output logic        icache_uncached,
  input  logic        icache_ready,
  output logic        icache_abort,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        if_exc,
  output logic [4:0]  if_exccode,
  output logic        if_tlb_refill
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] req_paddr_q;
  logic        req_unc_q;
  logic        ld_ok, ld_fault, latch;

  logic [31:0] mmu_paddr;
  logic        mmu_miss, mmu_invalid, mmu_illegal, mmu_unc;
  assign {mmu_paddr, mmu_miss, mmu_invalid, mmu_illegal, mmu_unc} = inst_mmu_result;

  logic adel, refill, inv, fault, slot_free;
  assign adel      = (pc_q[1:0] != 2'b00) | mmu_illegal;
  assign refill    = !adel & mmu_miss;
  assign inv       = !adel & !mmu_miss & mmu_invalid;
  assign fault     = adel | refill | inv;
  assign slot_free = !if_valid | !stall;

  assign inst_vaddr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    icache_req      = 1'b0;
    icache_paddr    = mmu_paddr;
    icache_uncached = mmu_unc;
    icache_abort    = 1'b0;
    ld_ok           = 1'b0;
    ld_fault        = 1'b0;
    latch           = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!flush && slot_free) begin
          if (fault) begin
            ld_fault = 1'b1;
            state_d  = ST_FAULT;
          end else begin
            icache_req = 1'b1;
            if (icache_ready) ld_ok = 1'b1;
            else begin
              latch   = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        // Slot is empty here, so stall does not gate the held request.
        icache_paddr    = req_paddr_q;
        icache_uncached = req_unc_q;
        if (flush) icache_abort = 1'b1;
        else begin
          icache_req = 1'b1;
          if (icache_ready) begin
            ld_ok   = 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      default: ;
    endcase
    if (flush) state_d = ST_RUN;
    // Drop the request as soon as reset asserts, without waiting for a clock.
    if (!rst) icache_req = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      req_paddr_q   <= '0;
      req_unc_q     <= 1'b0;
      if_valid      <= 1'b0;
      if_pc         <= '0;
      if_exc        <= 1'b0;
      if_exccode    <= '0;
      if_tlb_refill <= 1'b0;
    end else if (flush) begin
      pc_q     <= flush_pc;
      if_valid <= 1'b0;
    end else begin
      if (ld_ok) begin
        if_valid      <= 1'b1;
        if_pc         <= pc_q;
        if_exc        <= 1'b0;
        if_exccode    <= 5'd0;
        if_tlb_refill <= 1'b0;
        pc_q          <= pc_q + 32'd4;
      end else if (ld_fault) begin
        if_valid      <= 1'b1;
        if_pc         <= pc_q;
        if_exc        <= 1'b1;
        if_exccode    <= adel ? 5'd4 : 5'd2;
        if_tlb_refill <= refill;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
      if (latch) begin
        req_paddr_q <= mmu_paddr;
        req_unc_q   <= mmu_unc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_translate.sv
// Bench for inst_fetch_translate: directed scenarios plus random traffic,
// checked every cycle against a transaction-level fetch model.
module tb_inst_fetch_translate;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, flush, stall, icache_ready;
  logic [31:0] flush_pc;
  logic        t_miss, t_inv, t_ill;
  logic [31:0] inst_vaddr, icache_paddr, if_pc;
  logic [35:0] inst_mmu_result;
  logic        icache_req, icache_uncached, icache_abort;
  logic        if_valid, if_exc, if_tlb_refill;
  logic [4:0]  if_exccode;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inst_fetch_translate #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc), .stall(stall),
    .inst_vaddr(inst_vaddr), .inst_mmu_result(inst_mmu_result),
    .icache_req(icache_req), .icache_paddr(icache_paddr),
    .icache_uncached(icache_uncached), .icache_ready(icache_ready),
    .icache_abort(icache_abort), .if_valid(if_valid), .if_pc(if_pc),
    .if_exc(if_exc), .if_exccode(if_exccode), .if_tlb_refill(if_tlb_refill)
  );

  // MMU stand-in: kseg0/kseg1 unmapped, everything else mapped by an xor.
  function automatic logic [31:0] mmu_pa(input logic [31:0] va);
    if (va[31:30] == 2'b10) return va & 32'h1FFF_FFFF;
    return va ^ 32'h4000_0000;
  endfunction

  assign inst_mmu_result = {mmu_pa(inst_vaddr), t_miss, t_inv, t_ill,
                            inst_vaddr[31:29] == 3'b101};

  // Fetch model: a PC, one recorded slot, an outstanding request, a stuck flag.
  logic [31:0] m_pc, m_rec_pc, w_paddr;
  logic        m_valid, m_exc, m_refill, pending, stuck, w_unc;
  logic [4:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_rec_pc = 0; m_valid = 0; m_exc = 0; m_refill = 0;
    m_code = 0; pending = 0; stuck = 0; w_paddr = 0; w_unc = 0;
  endtask

  task automatic rec(input logic [31:0] pc, input logic e, input logic [4:0] c, input logic r);
    m_valid = 1; m_rec_pc = pc; m_exc = e; m_code = c; m_refill = r;
  endtask

  task automatic chk_slot();
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_pc", if_pc, m_rec_pc);
    chk("if_exc", 32'(if_exc), 32'(m_exc));
    chk("if_exccode", 32'(if_exccode), 32'(m_code));
    chk("if_tlb_refill", 32'(if_tlb_refill), 32'(m_refill));
  endtask

  task automatic cyc(input logic f, input logic [31:0] fp, input logic st,
                     input logic rd, input logic mi, input logic iv, input logic il);
    logic [31:0] pa;
    logic unc, adel, refill, inv, fault, free, ereq, eabort;
    @(negedge clk);
    flush = f; flush_pc = fp; stall = st; icache_ready = rd;
    t_miss = mi; t_inv = iv; t_ill = il;
    #1;
    pa     = mmu_pa(m_pc);
    unc    = (m_pc[31:29] == 3'b101);
    adel   = (m_pc % 4 != 0) || il;
    refill = !adel && mi;
    inv    = !adel && !mi && iv;
    fault  = adel || refill || inv;
    free   = !m_valid || !st;
    if (stuck)        ereq = 0;
    else if (pending) ereq = !f;
    else              ereq = free && !fault && !f;
    eabort = f && pending;
    chk("inst_vaddr", inst_vaddr, m_pc);
    chk("icache_req", 32'(icache_req), 32'(ereq));
    chk("icache_abort", 32'(icache_abort), 32'(eabort));
    if (ereq) begin
      chk("icache_paddr", icache_paddr, pending ? w_paddr : pa);
      chk("icache_uncached", 32'(icache_uncached), 32'(pending ? w_unc : unc));
    end
    chk_slot();
    @(posedge clk);
    if (f) begin
      m_pc = fp; m_valid = 0; pending = 0; stuck = 0;
    end else begin
      if (m_valid && !st) m_valid = 0;
      if (pending) begin
        if (rd) begin rec(m_pc, 0, 0, 0); m_pc = m_pc + 4; pending = 0; end
      end else if (!stuck && free) begin
        if (fault) begin rec(m_pc, 1, adel ? 5'd4 : 5'd2, refill); stuck = 1; end
        else if (rd) begin rec(m_pc, 0, 0, 0); m_pc = m_pc + 4; end
        else begin pending = 1; w_paddr = pa; w_unc = unc; end
      end
    end
  endtask

  logic [31:0] bases [6] = '{32'hBFC0_0000, 32'h0040_0000, 32'h8000_1000,
                             32'h0040_0002, 32'hFFFF_FFF0, 32'hA000_0100};

  initial begin
    rst = 0; flush = 0; flush_pc = 0; stall = 0; icache_ready = 0;
    t_miss = 0; t_inv = 0; t_ill = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(icache_req), 0);
    chk("rst_vaddr", inst_vaddr, RESET_PC);
    chk_slot();
    rst = 1;

    // Backpressure with stall toggling, then accept
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // TLB miss, stuck in fault for 10 cycles
    cyc(1, 32'h0040_0000, 0, 1, 1, 0, 0);
    repeat (11) cyc(0, 0, 0, 1, 1, 0, 0);
    // Priority: misaligned beats miss/invalid, then invalid alone
    cyc(1, 32'h0040_0002, 0, 1, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(1, 32'h0040_0000, 0, 1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 1, 0);
    // Downstream stall holds everything, release issues next fetch
    cyc(1, 32'hBFC0_0100, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    // Flush while waiting, with ready asserted in the same cycle
    cyc(1, 32'hBFC0_0200, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h8000_1000, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // PC wrap
    cyc(1, 32'hFFFF_FFFC, 0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] fp;
      fp = bases[$urandom_range(0, 5)] + ($urandom_range(0, 7) * 4);
      cyc($urandom_range(0, 11) == 0, fp, $urandom_range(0, 2) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    // Reset asserted while a request is held
    cyc(1, 32'hBFC0_0300, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wait_req_before_rst", 32'(icache_req), 1);
    rst = 0;
    #1;
    model_reset();
    chk("midrst_req", 32'(icache_req), 0);
    chk("midrst_abort", 32'(icache_abort), 0);
    chk("midrst_vaddr", inst_vaddr, RESET_PC);
    chk_slot();
    @(negedge clk);
    rst = 1;
    repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
